// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a small show-ahead receive FIFO.
// The serial line is synchronised, each frame is sampled mid-bit, and good
// bytes are queued for the CPU load path together with sticky error flags.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       sys_clk_i,
    input  logic       sys_rstn_i,
    input  logic       uart_tx_in,
    input  logic       uart_rd_i,
    input  logic       uart_clr_i,
    output logic [7:0] uart_data_o,
    output logic       uart_valid_o,
    output logic       uart_frame_err_o,
    output logic       uart_overrun_o
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchroniser and receiver state
    logic             sync1;
    logic             rxs;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             push;
    logic             frame_set;

    // FIFO state
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             pop;
    logic             do_write;
    logic             overrun_set;

    // Two-flop synchroniser; idles high so reset does not look like a start edge
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_tx_in;
            rxs   <= sync1;
        end
    end

    // Receiver state register: FSM state, bit-period counter, bit index, shifter
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
        end
    end

    // Next-state logic: half-bit wait in START, then one full bit period per sample
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        bit_next   = bit_idx;
        shift_next = shift;
        push       = 1'b0;
        frame_set  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rxs) begin
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign full        = (level == FULL_LVL);
    assign uart_valid_o = (level != '0);
    assign pop         = uart_rd_i && uart_valid_o;
    // When full, a simultaneous pop frees the head slot, which is also the write slot
    assign do_write    = push && (!full || pop);
    assign overrun_set = push && full && !pop;
    assign uart_data_o = uart_valid_o ? mem[rd_ptr] : '0;

    // FIFO storage; contents are masked at the output while empty, so no reset
    always_ff @(posedge sys_clk_i) begin
        if (do_write) begin
            mem[wr_ptr] <= shift;
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_write, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags; a new set event takes priority over clear
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            uart_frame_err_o <= 1'b0;
            uart_overrun_o   <= 1'b0;
        end else begin
            uart_frame_err_o <= frame_set   | (uart_frame_err_o & ~uart_clr_i);
            uart_overrun_o   <= overrun_set | (uart_overrun_o   & ~uart_clr_i);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a queue-based receiver model.
// The model knows only when each stop bit is sampled (pin fall + 2 + CPB/2 + 9*CPB)
// and applies push/pop/flag rules to a byte queue; one process compares every cycle.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int H     = CPB / 2;
    localparam int STOP_OFS = 2 + H + 9 * CPB;

    logic       clk;
    logic       rst_n;
    logic       tx;
    logic       rd;
    logic       clr;
    logic [7:0] uart_data_o;
    logic       uart_valid_o;
    logic       uart_frame_err_o;
    logic       uart_overrun_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         stop;
    } ev_t;

    ev_t        ev[$];
    logic [7:0] m_q[$];
    bit         m_fe;
    bit         m_ov;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sys_clk_i       (clk),
        .sys_rstn_i      (rst_n),
        .uart_tx_in      (tx),
        .uart_rd_i       (rd),
        .uart_clr_i      (clr),
        .uart_data_o     (uart_data_o),
        .uart_valid_o    (uart_valid_o),
        .uart_frame_err_o(uart_frame_err_o),
        .uart_overrun_o  (uart_overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: cycle n runs from posedge n to posedge n+1
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    // Drive one 8N1 frame starting this cycle; registers the stop-sample event
    task automatic send(input logic [7:0] d, input bit stop);
        ev_t e;
        e.at   = cyc + STOP_OFS;
        e.data = d;
        e.stop = stop;
        ev.push_back(e);
        tx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            tx = d[i];
            step(CPB);
        end
        tx = stop;
        step(CPB);
        tx = 1'b1;
    endtask

    task automatic read_byte(input logic [7:0] exp);
        chk("read_valid", uart_valid_o, 1);
        chk("read_data", uart_data_o, exp);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    // Model compare then advance, on every falling edge
    always @(negedge clk) begin
        bit pop;
        bit fe_set;
        bit ov_set;
        int sz;
        if (!rst_n) begin
            m_q.delete();
            ev.delete();
            m_fe = 1'b0;
            m_ov = 1'b0;
        end
        chk("m_valid", uart_valid_o, (m_q.size() != 0) ? 1 : 0);
        chk("m_data", uart_data_o, (m_q.size() != 0) ? m_q[0] : 8'h00);
        chk("m_frame_err", uart_frame_err_o, m_fe);
        chk("m_overrun", uart_overrun_o, m_ov);
        if (rst_n) begin
            sz     = m_q.size();
            pop    = rd && (sz != 0);
            fe_set = 1'b0;
            ov_set = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (ev.size() != 0 && ev[0].at == cyc) begin
                if (ev[0].stop) begin
                    if (sz < DEPTH || pop) m_q.push_back(ev[0].data);
                    else ov_set = 1'b1;
                end else begin
                    fe_set = 1'b1;
                end
                void'(ev.pop_front());
            end
            m_fe = fe_set | (m_fe & !clr);
            m_ov = ov_set | (m_ov & !clr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        tx    = 1'b1;
        rd    = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        chk("reset_valid", uart_valid_o, 0);
        chk("reset_data", uart_data_o, 0);
        chk("reset_fe", uart_frame_err_o, 0);
        chk("reset_ov", uart_overrun_o, 0);
        step(5);

        // 1: single byte, exact latency, then pop
        s = cyc + STOP_OFS;
        fork
            send(8'h55, 1'b1);
            begin
                step_to(s);
                chk("t1_valid_before", uart_valid_o, 0);
                step(1);
                chk("t1_valid_at_155", uart_valid_o, 1);
                chk("t1_data", uart_data_o, 8'h55);
                chk("t1_fe", uart_frame_err_o, 0);
            end
        join
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        chk("t1_valid_after_pop", uart_valid_o, 0);
        chk("t1_data_after_pop", uart_data_o, 0);
        step(CPB);

        // 2: back-to-back frames
        send(8'hA3, 1'b1);
        send(8'h0F, 1'b1);
        step(2);
        read_byte(8'hA3);
        read_byte(8'h0F);
        chk("t2_empty", uart_valid_o, 0);
        chk("t2_fe", uart_frame_err_o, 0);
        step(CPB);

        // 3: start-bit glitch
        tx = 1'b0;
        step(4);
        tx = 1'b1;
        step(3 * CPB);
        chk("t3_valid", uart_valid_o, 0);
        chk("t3_fe", uart_frame_err_o, 0);
        chk("t3_ov", uart_overrun_o, 0);

        // 4: framing error, clear, then good byte
        s = cyc + STOP_OFS;
        fork
            send(8'h7E, 1'b0);
            begin
                step_to(s + 1);
                chk("t4_fe_set", uart_frame_err_o, 1);
                chk("t4_valid", uart_valid_o, 0);
            end
        join
        step(2 * CPB);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("t4_fe_cleared", uart_frame_err_o, 0);
        send(8'h31, 1'b1);
        step(2);
        read_byte(8'h31);
        step(CPB);

        // 5a: overrun on fifth byte
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        s = cyc + STOP_OFS;
        fork
            send(8'h05, 1'b1);
            begin
                step_to(s);
                chk("t5_ov_before", uart_overrun_o, 0);
                step(1);
                chk("t5_ov_set", uart_overrun_o, 1);
            end
        join
        step(2);
        for (int i = 1; i <= 4; i++) read_byte(8'(i));
        chk("t5_empty", uart_valid_o, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("t5_ov_cleared", uart_overrun_o, 0);

        // 5b: pop coincident with the fifth push
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        s = cyc + STOP_OFS;
        fork
            send(8'h05, 1'b1);
            begin
                step_to(s);
                rd = 1'b1;
                step(1);
                rd = 1'b0;
                chk("t5b_no_ov", uart_overrun_o, 0);
            end
        join
        step(2);
        for (int i = 2; i <= 5; i++) read_byte(8'(i));
        chk("t5b_empty", uart_valid_o, 0);
        step(CPB);

        // 6: reset mid-frame with a byte queued
        send(8'h11, 1'b1);
        step(2);
        chk("t6_queued", uart_valid_o, 1);
        tx = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            tx = (8'hC6 >> i) & 8'h01;
            step((i == 3) ? H : CPB);
        end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", uart_valid_o, 0);
        chk("t6_rst_data", uart_data_o, 0);
        chk("t6_rst_fe", uart_frame_err_o, 0);
        chk("t6_rst_ov", uart_overrun_o, 0);
        tx = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(5);
        send(8'h9D, 1'b1);
        step(2 * CPB);
        read_byte(8'h9D);
        chk("t6_empty", uart_valid_o, 0);
        chk("t6_fe", uart_frame_err_o, 0);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the existing `uart` transmitter. It deserialises the incoming serial line into bytes and buffers them in a small show-ahead FIFO. The CPU reads the FIFO through a memory-mapped load path: the data byte, a valid flag and error flags. A pop strobe is asserted on the CPU's load of the RX data address.

Parameters:
CLKS_PER_BIT, 868, sys_clk_i cycles per bit period (100 MHz / 115200); must be >= 4
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2

Ports:
sys_clk_i  in  1  system clock, all state on rising edge
sys_rstn_i  in  1  asynchronous active-low reset
uart_tx_in  in  1  serial input from host; idle high
uart_rd_i  in  1  pop strobe; removes head entry when uart_valid_o=1
uart_clr_i  in  1  clears sticky error flags
uart_data_o  out  8  FIFO head byte (show-ahead); 0 when empty
uart_valid_o  out  1  FIFO non-empty
uart_frame_err_o  out  1  sticky: a frame was received with stop bit = 0
uart_overrun_o  out  1  sticky: a good byte arrived while the FIFO was full and was dropped

Behaviour:
- Reset (async assert, sync release): both synchroniser flops = 1; FSM = IDLE; bit/cycle counters = 0; FIFO empty (ptrs = 0); all outputs 0.
- Input path: 2-flop synchroniser on uart_tx_in; the FSM sees only the synchronised value `rxs` (2-cycle pin delay).
- FSM states: IDLE, START, DATA, STOP.
- t0 is the first cycle in IDLE with rxs=0.
- IDLE -> START at t0; cycle counter cleared.
- START: samples rxs at t0 + CLKS_PER_BIT/2 (integer division).
  - rxs=1: glitch; return to IDLE, nothing recorded.
  - rxs=0: go to DATA; counter cleared.
- DATA: data bit i (i = 0..7, LSB first) sampled at t0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT; shifted into the shift register. After bit 7: go to STOP.
- STOP: samples rxs at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - rxs=1: push the byte.
  - rxs=0: set uart_frame_err_o; discard the byte.
  - Either case: go to IDLE in the same cycle (mid-stop-bit), so back-to-back frames are accepted.
- Push timing: the push is registered; uart_valid_o and uart_data_o are updated the cycle after the stop sample.
- FIFO:
  - Count width = log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - uart_data_o = mem[rd_ptr] when non-empty, else 0.
  - Pop only when uart_rd_i && uart_valid_o; uart_rd_i while empty is ignored.
  - Push and pop in the same cycle: both occur, count unchanged. This holds even when full, so no overrun is flagged.
  - Push while full with no pop: byte dropped, uart_overrun_o set, FIFO contents unchanged.
- Sticky flags: stay set until uart_clr_i or reset. If uart_clr_i coincides with a new set event, the set wins.
- Reset asserted mid-frame: frame abandoned, FIFO flushed. After release, the FSM waits in IDLE for the next falling edge; a line held low at release is treated as a start edge.
- No parity, no break detection, no auto-baud.

Test Plan:
(all with CLKS_PER_BIT=16, FIFO_DEPTH=4)
1. Send 0x55, stop=1 -> uart_valid_o=1 and uart_data_o=0x55 exactly 2+8+9*16+1 cycles after the falling edge on the pin; frame_err=0. Pulse uart_rd_i -> valid=0 and data=0 next cycle.
2. Send 0xA3 then 0x0F back-to-back (no idle gap) -> two reads return 0xA3 then 0x0F; no error flags.
3. Pull line low for 4 cycles, then high -> FSM returns to IDLE; valid stays 0; no flags.
4. Send 0x7E with stop bit=0 -> uart_frame_err_o=1, valid=0. Then pulse uart_clr_i -> flag=0. Then send 0x31 -> received correctly.
5. Send 0x01..0x05 without reading -> overrun=1 after 5th stop sample; reads return 0x01..0x04 then valid=0. Repeat with uart_rd_i pulsed on the 5th push cycle -> no overrun.
6. Assert sys_rstn_i low during bit 3 of 0xC6 with one byte already queued -> all outputs 0 immediately. After release, send 0x9D -> only 0x9D received.
